fetch_prefetch_unit: RTL and testbench
======================================

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: PC and instruction-memory address width.
REQ-002 Parameter INSN_W, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: prefetch buffer entries; power of two, DEPTH >= 2.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 imem_en  output  1  fetch request to instruction memory this cycle.
REQ-009 imem_addr  output  ADDR_W  fetch address; valid when imem_en=1.
REQ-010 imem_rdata  input  INSN_W  instruction word; fixed one-cycle latency after imem_en.
REQ-011 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  input  ADDR_W  new fetch address; sampled when redirect_valid=1.
REQ-013 if_valid  output  1  head entry presented to decode.
REQ-014 if_instr  output  INSN_W  head instruction.
REQ-015 if_pc  output  ADDR_W  address of head instruction.
REQ-016 if_pc4  output  ADDR_W  if_pc + 4, modulo 2^ADDR_W.
REQ-017 id_ready  input  1  decode accepts head; transfer occurs when if_valid && id_ready.
REQ-018 buf_count  output  clog2(DEPTH+1)  current occupied entries.

Function
REQ-019 The block SHALL hold fetch_pc; each issued fetch SHALL drive imem_addr=fetch_pc and advance fetch_pc by 4, wrapping modulo 2^ADDR_W.
REQ-020 imem_en SHALL assert iff no redirect this cycle and buf_count + inflight - pop < DEPTH, where pop = if_valid && id_ready and inflight = fetch issued in previous cycle.
REQ-021 A returned word SHALL be written into the buffer tail, tagged with its fetch address, in the cycle imem_rdata is valid, unless discarded by REQ-024.
REQ-022 if_valid SHALL equal (buf_count != 0); if_instr/if_pc present the oldest entry; no combinational bypass from imem_rdata to if_*.
REQ-023 Simultaneous push and pop SHALL leave buf_count unchanged; the buffer SHALL never overflow or underflow, and pointers wrap modulo DEPTH.
REQ-024 On redirect_valid=1: buffer emptied (buf_count=0 next cycle), any in-flight response discarded, fetch_pc <= redirect_pc, imem_en=0 that cycle, any same-cycle pop ignored by decode.
REQ-025 A fetch SHALL be issued at redirect_pc in the cycle after redirect, subject to REQ-020.
REQ-026 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-027 With id_ready held high and no redirect, steady-state throughput SHALL be one instruction per cycle.
REQ-028 With id_ready low, the head entry and if_* outputs SHALL remain stable until accepted or flushed.

Reset
REQ-029 While reset=1: fetch_pc=RESET_PC, buf_count=0, inflight=0, if_valid=0, imem_en=0; reset overrides redirect_valid.
REQ-030 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions.
REQ-031 The first fetch (imem_addr=RESET_PC) SHALL issue in the first cycle after reset deasserts; if_valid SHALL rise two cycles after reset deasserts.
REQ-032 if_instr, if_pc and if_pc4 SHALL read 0 while if_valid=0 after reset.

Structure
REQ-033 Shared package fetch_pkg SHALL hold the PC increment constant (4), default RESET_PC and the buffer entry record type {pc, instr}.
REQ-034 The buffer SHALL be a separate sub-module fetch_fifo (synchronous, parameterised by width and DEPTH, with push, pop, clear and count).
REQ-035 Entry count, credit check and epoch/discard logic SHALL stay in fetch_prefetch_unit.

Verification
REQ-036 Reset release, RESET_PC=0, id_ready=1, memory returns addr|0xA000_0000 -> imem_addr 0,4,8,... consecutive cycles; if_valid at cycle 2; if_pc 0,4,8 one per cycle.
REQ-037 id_ready=0 for 10 cycles, DEPTH=4 -> buf_count saturates at 4, imem_en=0 once full, if_pc stays 0x0; id_ready=1 -> 0x4,0x8,0xC,0x10 on consecutive cycles, no gaps.
REQ-038 redirect_valid=1, redirect_pc=0x100 with 3 buffered entries and one in flight -> next cycle buf_count=0, if_valid=0, imem_addr=0x100; stale word never appears; if_pc=0x100 two cycles later.
REQ-039 Redirects to 0x200 then 0x300 on consecutive cycles -> only 0x300 fetched; first valid if_pc=0x300.
REQ-040 redirect_pc=0xFFFF_FFFC, ADDR_W=32 -> fetch sequence 0xFFFF_FFFC, 0x0; if_pc4 of first entry = 0x0.
REQ-041 reset asserted for one cycle with full buffer -> buf_count=0, if_valid=0; refetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch-buffer entry layout for the fetch stage.
package fetch_pkg;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEF_ADDR_W       = 32;
    localparam int          DEF_INSN_W       = 32;

    // Entry layout; the top packs {pc, instr} in this order into the buffer.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INSN_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear and occupancy count; pointers wrap modulo DEPTH.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the count gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch: credit-limited sequential fetch into a small buffer, with redirect flush.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter  int                ADDR_W   = 32,
    parameter  int                INSN_W   = 32,
    parameter  int                DEPTH    = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    localparam int                CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [INSN_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    input  logic              id_ready,
    output logic [CW-1:0]     buf_count
);

    localparam int EW = ADDR_W + INSN_W;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic              inflight_q;
    logic              pop_req;
    logic              push;
    logic [CW:0]       occupancy;
    logic              fifo_empty;
    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_pc;
    logic [INSN_W-1:0] head_instr;

    assign pop_req = if_valid && id_ready;

    // Credit check counts the in-flight word so the buffer can never overflow.
    assign occupancy = {1'b0, buf_count} + (CW+1)'(inflight_q) - (CW+1)'(pop_req);
    assign imem_en   = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;

    // A response landing in a redirect cycle belongs to the old stream and is dropped.
    assign push = inflight_q && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (imem_en) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= imem_en;
            if (imem_en) begin
                req_pc_q <= fetch_pc_q;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect_valid),
        .push  (push),
        .wdata ({req_pc_q, imem_rdata}),
        .pop   (pop_req && !redirect_valid),
        .rdata (head),
        .count (buf_count),
        .empty (fifo_empty)
    );

    assign head_pc    = head[EW-1:INSN_W];
    assign head_instr = head[INSN_W-1:0];

    assign if_valid = !fifo_empty;
    assign if_instr = if_valid ? head_instr : '0;
    assign if_pc    = if_valid ? head_pc : '0;
    assign if_pc4   = if_valid ? head_pc + ADDR_W'(PC_INC) : '0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a one-cycle-latency memory model.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready;
    logic [2:0]  buf_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr | 32'hA000_0000;
    end

    fetch_prefetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .id_ready       (id_ready),
        .buf_count      (buf_count)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in cycle 0: the first cycle with reset low.
    task automatic do_reset(input logic rdy);
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = rdy;
        tick(); tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0700; id_ready = 1'b1;
        tick(); tick();
        #1;
        n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en got %b want 0", imem_en); end
        n_checks++; if (buf_count !== 3'd0) begin n_fail++; $display("FAIL reset_buf_count got %0d want 0", buf_count); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
        n_checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc4 !== 32'h0)
            begin n_fail++; $display("FAIL reset_if_zero got instr=%h pc=%h pc4=%h want 0", if_instr, if_pc, if_pc4); end
        redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL reset_first_fetch got en=%b addr=%h want 1/0", imem_en, imem_addr); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'(4 * k))
                begin n_fail++; $display("FAIL stream_fetch c%0d got en=%b addr=%h want 1/%h", k, imem_en, imem_addr, 4 * k); end
            if (k < 2) begin
                n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c%0d got %b want 0", k, if_valid); end
            end else begin
                n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (k - 2)) || if_instr !== (32'(4 * (k - 2)) | 32'hA000_0000))
                    begin n_fail++; $display("FAIL stream_head c%0d got v=%b pc=%h instr=%h want pc=%h", k, if_valid, if_pc, if_instr, 4 * (k - 2)); end
            end
            if (k < 7) tick();
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k >= 4) begin
                n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL stall_imem_en c%0d got %b want 0", k, imem_en); end
            end
            if (k < 9) tick();
        end
        n_checks++; if (buf_count !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", buf_count); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL stall_head got %h want 0", if_pc); end
        tick();
        id_ready = 1'b1;
        #1;
        n_checks++; if (if_pc !== 32'h0 || imem_en !== 1'b1 || imem_addr !== 32'h10)
            begin n_fail++; $display("FAIL stall_release got pc=%h en=%b addr=%h want 0/1/10", if_pc, imem_en, imem_addr); end
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * j))
                begin n_fail++; $display("FAIL stall_drain %0d got v=%b pc=%h want %h", j, if_valid, if_pc, 4 * j); end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        tick(); tick(); tick(); tick();
        n_checks++; if (buf_count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got %0d want 3", buf_count); end
        redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
        #1;
        n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL redir_imem_en got %b want 0", imem_en); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (buf_count !== 3'd0 || if_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 32'h100)
            begin n_fail++; $display("FAIL redir_next got cnt=%0d v=%b en=%b addr=%h want 0/0/1/100", buf_count, if_valid, imem_en, imem_addr); end
        tick();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale got v=%b pc=%h want empty", if_valid, if_pc); end
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hA000_0100)
            begin n_fail++; $display("FAIL redir_head got v=%b pc=%h instr=%h want 100/a0000100", if_valid, if_pc, if_instr); end
        tick();
        n_checks++; if (if_pc !== 32'h104) begin n_fail++; $display("FAIL redir_second got %h want 104", if_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL b2b_first_en got %b want 0", imem_en); end
        tick();
        redirect_pc = 32'h300;
        #1;
        n_checks++; if (imem_en !== 1'b0 || buf_count !== 3'd0)
            begin n_fail++; $display("FAIL b2b_second got en=%b cnt=%0d want 0/0", imem_en, buf_count); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h300 || if_valid !== 1'b0)
            begin n_fail++; $display("FAIL b2b_fetch got en=%b addr=%h v=%b want 1/300/0", imem_en, imem_addr, if_valid); end
        tick();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got v=%b pc=%h want empty", if_valid, if_pc); end
        tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'hA000_0300)
            begin n_fail++; $display("FAIL b2b_head got v=%b pc=%h instr=%h want 300", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wrap_fetch0 got en=%b addr=%h want fffffffc", imem_en, imem_addr); end
        tick();
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL wrap_fetch1 got en=%b addr=%h want 0", imem_en, imem_addr); end
        tick();
        n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || if_instr !== 32'hFFFF_FFFC)
            begin n_fail++; $display("FAIL wrap_head got pc=%h pc4=%h instr=%h want fffffffc/0/fffffffc", if_pc, if_pc4, if_instr); end
        tick();
        n_checks++; if (if_pc !== 32'h0 || if_pc4 !== 32'h4 || if_instr !== 32'hA000_0000)
            begin n_fail++; $display("FAIL wrap_next got pc=%h pc4=%h instr=%h want 0/4/a0000000", if_pc, if_pc4, if_instr); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) tick();
        n_checks++; if (buf_count !== 3'd4 || if_valid !== 1'b1)
            begin n_fail++; $display("FAIL rstmid_full got cnt=%0d v=%b want 4/1", buf_count, if_valid); end
        tick();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        #1;
        n_checks++; if (imem_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_en got %b want 0", imem_en); end
        tick();
        reset = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        #1;
        n_checks++; if (buf_count !== 3'd0 || if_valid !== 1'b0 || if_pc !== 32'h0)
            begin n_fail++; $display("FAIL rstmid_flush got cnt=%0d v=%b pc=%h want 0/0/0", buf_count, if_valid, if_pc); end
        n_checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL rstmid_refetch got en=%b addr=%h want 1/0", imem_en, imem_addr); end
        tick(); tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA000_0000)
            begin n_fail++; $display("FAIL rstmid_head got v=%b pc=%h instr=%h want 1/0/a0000000", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
